// File: rtl/atan_ratio_prep.sv
// atan_ratio_prep: reduces a signed (x, y) pair to an octant code and the
// unsigned Q0.8 ratio min(|x|,|y|)/max(|x|,|y|), ready for the atan
// polynomial stage that follows.
//
// The ratio comes from a restoring divider that produces one quotient bit
// per cycle. A zero vector (max == 0) yields ratio 0 and octant 000, and a
// ratio of exactly 1.0 saturates to 255.
//
// Configuration macro: ATAN_RATIO_PREP_ROUND_EN
//   undefined : 8 quotient bits, truncated result, latency 10 edges
//   defined   : 9 quotient bits, round-half-up result, latency 11 edges
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its data stable while valid is high and
// ready is low. in_ready_o is high only in IDLE. out_valid_o stays high with
// stable data until out_ready_i is seen high.
module atan_ratio_prep #(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] y_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [7:0]               atan_poly_o,
  output logic [2:0]               octant_o,
  output logic [1:0]               state_o
);

`ifdef ATAN_RATIO_PREP_ROUND_EN
  localparam int QB = 9;
`else
  localparam int QB = 8;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ABS  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                     r_state;
  logic signed [DATA_W-1:0]   r_x;
  logic signed [DATA_W-1:0]   r_y;
  logic [DATA_W-1:0]          r_min;
  logic [DATA_W-1:0]          r_max;
  logic [DATA_W-1:0]          r_rem;
  logic [QB-1:0]              r_quo;
  logic [3:0]                 r_cnt;
  logic [2:0]                 r_oct;
  logic                       r_zero;
  logic                       r_in_ready;
  logic                       r_out_valid;
  logic [7:0]                 r_poly;
  logic [2:0]                 r_octant;

  // Magnitudes are unsigned, so -2^(DATA_W-1) becomes 2^(DATA_W-1) exactly.
  logic [DATA_W-1:0] w_abs_x;
  logic [DATA_W-1:0] w_abs_y;
  logic              w_y_gt_x;
  logic [DATA_W-1:0] w_min;
  logic [DATA_W-1:0] w_max;

  assign w_abs_x  = r_x[DATA_W-1] ? DATA_W'(-r_x) : DATA_W'(r_x);
  assign w_abs_y  = r_y[DATA_W-1] ? DATA_W'(-r_y) : DATA_W'(r_y);
  assign w_y_gt_x = (w_abs_y > w_abs_x);
  assign w_min    = w_y_gt_x ? w_abs_x : w_abs_y;
  assign w_max    = w_y_gt_x ? w_abs_y : w_abs_x;

  // One restoring-division step. The remainder never exceeds max, so it
  // fits in DATA_W bits; only the shifted trial value needs one more bit.
  logic [DATA_W:0]   w_rem_sh;
  logic              w_ge;
  logic [DATA_W:0]   w_rem_sub;
  logic [DATA_W-1:0] w_rem_nx;

  assign w_rem_sh  = {r_rem, 1'b0};
  assign w_ge      = (w_rem_sh >= {1'b0, r_max});
  assign w_rem_sub = w_rem_sh - {1'b0, r_max};
  assign w_rem_nx  = w_ge ? w_rem_sub[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];

  // Final ratio: rounding or truncation, saturation to 255, zero-vector force.
  logic [7:0] w_sat;
  logic [7:0] w_poly;

`ifdef ATAN_RATIO_PREP_ROUND_EN
  logic [QB:0]   w_q_inc;
  logic [QB-1:0] w_rnd;
  assign w_q_inc = {1'b0, r_quo} + (QB+1)'(1);
  assign w_rnd   = w_q_inc[QB:1];
  assign w_sat   = w_rnd[QB-1] ? 8'hFF : w_rnd[7:0];
`else
  // With min == max every quotient bit comes out 1, so 255 appears naturally.
  assign w_sat   = r_quo;
`endif

  assign w_poly = r_zero ? 8'd0 : w_sat;

  // Control FSM and datapath registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_min       <= '0;
      r_max       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      r_oct       <= '0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_poly      <= '0;
      r_octant    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid_i) begin
            r_x        <= x_i;
            r_y        <= y_i;
            r_in_ready <= 1'b0;
            r_state    <= S_ABS;
          end
        end
        S_ABS: begin
          r_min   <= w_min;
          r_max   <= w_max;
          r_rem   <= w_min;
          r_quo   <= '0;
          r_cnt   <= '0;
          r_oct   <= {r_y[DATA_W-1], r_x[DATA_W-1], w_y_gt_x};
          r_zero  <= (w_max == '0);
          r_state <= S_DIV;
        end
        S_DIV: begin
          if (r_cnt == 4'(QB)) begin
            r_poly      <= w_poly;
            r_octant    <= r_zero ? 3'b000 : r_oct;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= {r_quo[QB-2:0], w_ge};
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign atan_poly_o = r_poly;
  assign octant_o    = r_octant;
  assign state_o     = r_state;

endmodule

// File: tb/tb_atan_ratio_prep.sv
// Directed bench for atan_ratio_prep: reset state, ratio/octant vectors,
// output back-pressure, and reset during a division.
module tb_atan_ratio_prep;

`ifdef ATAN_RATIO_PREP_ROUND_EN
  localparam int LAT    = 11;
  localparam int ROUND  = 1;
`else
  localparam int LAT    = 10;
  localparam int ROUND  = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               in_valid_i;
  logic               in_ready_o;
  logic signed [15:0] x_i;
  logic signed [15:0] y_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [7:0]         atan_poly_o;
  logic [2:0]         octant_o;
  logic [1:0]         state_o;

  int checks = 0;
  int errors = 0;

  atan_ratio_prep #(.DATA_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .x_i         (x_i),
    .y_i         (y_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .atan_poly_o (atan_poly_o),
    .octant_o    (octant_o),
    .state_o     (state_o)
  );

  // driver: present a pair for one edge; ends #1 after that edge
  task automatic do_accept(input int x, input int y);
    in_valid_i = 1'b1;
    x_i = 16'(x);
    y_i = 16'(y);
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  // waits for out_valid_o, counting edges since the accept edge (max 30)
  task automatic wait_valid(output int k);
    k = 0;
    while (!out_valid_o && k < 30) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", in_ready_o); end
    checks++; if (atan_poly_o !== 8'd0) begin errors++; $display("FAIL reset_poly got %0d want 0", atan_poly_o); end
    checks++; if (octant_o !== 3'b000) begin errors++; $display("FAIL reset_oct got %b want 000", octant_o); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // hand-computed vectors: x, y, truncated, rounded, octant
  task automatic test_ratios();
    int         vx[9]  = '{100, 3, 10, -32768, 0, -1, -7, 32767, -200};
    int         vy[9]  = '{50, 2, -30, -32768, 0, 0, 7, -32768, 300};
    int         vt[9]  = '{128, 170, 85, 255, 0, 0, 255, 255, 170};
    int         vr[9]  = '{128, 171, 85, 255, 0, 0, 255, 255, 171};
    logic [2:0] vo[9]  = '{3'b000, 3'b000, 3'b101, 3'b110, 3'b000,
                           3'b010, 3'b010, 3'b101, 3'b011};
    int         k;
    int         exp_p;
    out_ready_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      exp_p = (ROUND != 0) ? vr[i] : vt[i];
      do_accept(vx[i], vy[i]);
      checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL busy_ready[%0d] got %0b want 0", i, in_ready_o); end
      wait_valid(k);
      checks++; if (k != LAT) begin errors++; $display("FAIL latency[%0d] got %0d want %0d", i, k, LAT); end
      checks++; if (atan_poly_o !== 8'(exp_p)) begin errors++; $display("FAIL poly[%0d] x=%0d y=%0d got %0d want %0d", i, vx[i], vy[i], atan_poly_o, exp_p); end
      checks++; if (octant_o !== vo[i]) begin errors++; $display("FAIL oct[%0d] got %b want %b", i, octant_o, vo[i]); end
      @(posedge clk);
      #1;
      checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin errors++; $display("FAIL drain[%0d] valid=%0b ready=%0b want 0/1", i, out_valid_o, in_ready_o); end
      checks++; if (atan_poly_o !== 8'(exp_p) || octant_o !== vo[i]) begin errors++; $display("FAIL hold_idle[%0d] poly=%0d oct=%b want %0d/%b", i, atan_poly_o, octant_o, exp_p, vo[i]); end
    end
  endtask

  task automatic test_backpressure();
    int k;
    int exp_p;
    exp_p = (ROUND != 0) ? 171 : 170;
    out_ready_i = 1'b0;
    do_accept(3, 2);
    wait_valid(k);
    checks++; if (k != LAT) begin errors++; $display("FAIL bp_latency got %0d want %0d", k, LAT); end
    for (int c = 0; c < 5; c++) begin
      in_valid_i = 1'b1;
      x_i = 16'(c * 7 + 1);
      y_i = -16'sd5;
      @(posedge clk);
      #1;
      checks++; if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_hs[%0d] valid=%0b ready=%0b want 1/0", c, out_valid_o, in_ready_o); end
      checks++; if (atan_poly_o !== 8'(exp_p) || octant_o !== 3'b000) begin errors++; $display("FAIL bp_data[%0d] poly=%0d oct=%b want %0d/000", c, atan_poly_o, octant_o, exp_p); end
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || state_o !== 2'd0) begin errors++; $display("FAIL bp_release valid=%0b ready=%0b state=%0d want 0/1/0", out_valid_o, in_ready_o, state_o); end
    @(posedge clk);
    #1;
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL bp_no_accept state=%0d want 0", state_o); end
  endtask

  task automatic test_reset_mid();
    int k;
    int seen;
    out_ready_i = 1'b1;
    do_accept(-200, 300);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin errors++; $display("FAIL mid_rst_hs valid=%0b ready=%0b want 0/1", out_valid_o, in_ready_o); end
    checks++; if (atan_poly_o !== 8'd0 || octant_o !== 3'b000) begin errors++; $display("FAIL mid_rst_data poly=%0d oct=%b want 0/000", atan_poly_o, octant_o); end
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (out_valid_o) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_rst_ghost valid cycles=%0d want 0", seen); end
    do_accept(100, 50);
    wait_valid(k);
    checks++; if (k != LAT) begin errors++; $display("FAIL post_rst_latency got %0d want %0d", k, LAT); end
    checks++; if (atan_poly_o !== 8'd128 || octant_o !== 3'b000) begin errors++; $display("FAIL post_rst_result poly=%0d oct=%b want 128/000", atan_poly_o, octant_o); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    in_valid_i  = 1'b0;
    x_i         = '0;
    y_i         = '0;
    out_ready_i = 1'b1;
    test_reset();
    test_ratios();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
